serial_deserializer8: RTL



---
 rtl/serial_deserializer8.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/serial_deserializer8.sv
// -----------------------------------------------------------------------------
// serial_deserializer8
//
// Serial-in, parallel-out byte receiver for the on-board serial link. The bits
// come from the 8-bit rotating shift register, which sends LSB first. Each bit
// arrives with a SerialValid strobe and shifts into an internal assembly
// register. When a byte is complete it moves into a one-entry holding
// register. A downstream consumer drains that register with a valid/ready
// handshake.
//
// Optional feature: define PARITY_CHECK_EN to enable parity checking. Each
// frame then carries 8 data bits followed by 1 even-parity bit, and
// ParityError reports the check result for the byte in DATA_OUT. When the
// macro is undefined, frames are 8 bits and ParityError is tied to 0.
//
// Handshake: the holding register presents DATA_OUT while ByteValid=1. The
// byte is consumed on any rising edge where ByteValid=1 and ByteReady=1.
// ByteValid does not depend on ByteReady. If a new byte completes on the same
// edge as a consumption, it loads into the holding register and ByteValid
// stays 1.
//
// Ports:
//   clock        in   rising-edge clock for all state
//   reset        in   synchronous, active-high; clears all state
//   SerialIn     in   serial data bit, sampled when SerialValid=1
//   SerialValid  in   bit strobe
//   Align        in   frame resync: drops any partial frame. A bit strobed on
//                     the same edge becomes bit 0 of the new frame.
//   DATA_OUT     out  [7:0] holding-register byte
//   ByteValid    out  holding register is full
//   ByteReady    in   consumer ready
//   Overflow     out  sticky: a completed byte was dropped (cleared by reset)
//   ParityError  out  parity status of the byte in DATA_OUT
//   state_dbg    out  current FSM state (0 = COLLECT, 1 = PARITY)
// -----------------------------------------------------------------------------
module serial_deserializer8 (
   input  logic       clock,
   input  logic       reset,
   input  logic       SerialIn,
   input  logic       SerialValid,
   input  logic       Align,
   output logic [7:0] DATA_OUT,
   output logic       ByteValid,
   input  logic       ByteReady,
   output logic       Overflow,
   output logic       ParityError,
   output logic       state_dbg
);

`ifdef PARITY_CHECK_EN
   typedef enum logic {COLLECT = 1'b0, PARITY = 1'b1} state_t;
`else
   typedef enum logic {COLLECT = 1'b0} state_t;
`endif

   state_t     state;
   logic [2:0] count;
   logic [7:0] shreg;

   logic [2:0] count_start;   // counter value after Align has been applied
   logic [7:0] shifted;       // assembly register with the current bit shifted in
   logic [7:0] done_data;     // byte delivered when a frame completes
   logic       byte_done;
   logic       load;
   logic       accept;
   logic       done_perr;

`ifdef PARITY_CHECK_EN
   state_t     state_eff;
   logic       perr_q;
`endif

   always_comb begin
      count_start = Align ? 3'd0 : count;
      shifted     = {SerialIn, shreg[7:1]};
      accept      = ByteValid & ByteReady;
`ifdef PARITY_CHECK_EN
      state_eff   = Align ? COLLECT : state;
      // The parity bit completes the frame. It is not shifted in, so the
      // assembly register still holds the 8 data bits.
      byte_done   = SerialValid && (state_eff == PARITY);
      done_data   = shreg;
      done_perr   = (^shreg) ^ SerialIn;
`else
      byte_done   = SerialValid && (count_start == 3'd7);
      done_data   = shifted;
      done_perr   = 1'b0;
`endif
      // The holding register can take a new byte if it is empty or if it is
      // being drained on this same edge.
      load        = byte_done && (!ByteValid || ByteReady);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= COLLECT;
         count     <= 3'd0;
         shreg     <= 8'h00;
         DATA_OUT  <= 8'h00;
         ByteValid <= 1'b0;
         Overflow  <= 1'b0;
`ifdef PARITY_CHECK_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         // Assembly side
         if (SerialValid) begin
`ifdef PARITY_CHECK_EN
            if (state_eff == COLLECT) begin
               shreg <= shifted;
               if (count_start == 3'd7) begin
                  // The counter stays at 7 while the parity bit is pending.
                  state <= PARITY;
                  count <= 3'd7;
               end else begin
                  state <= COLLECT;
                  count <= count_start + 3'd1;
               end
            end else begin
               state <= COLLECT;
               count <= 3'd0;
            end
`else
            shreg <= shifted;
            count <= count_start + 3'd1;   // wraps from 7 back to 0
            state <= COLLECT;
`endif
         end else if (Align) begin
            count <= 3'd0;
            state <= COLLECT;
         end

         // Holding-register side
         if (load) begin
            DATA_OUT  <= done_data;
            ByteValid <= 1'b1;
`ifdef PARITY_CHECK_EN
            perr_q    <= done_perr;
`endif
         end else if (accept) begin
            ByteValid <= 1'b0;
         end

         if (byte_done && !load)
            Overflow <= 1'b1;
      end
   end

`ifdef PARITY_CHECK_EN
   assign ParityError = perr_q;
`else
   assign ParityError = 1'b0;
   logic unused_perr;
   assign unused_perr = done_perr;
`endif

   assign state_dbg = state;

endmodule
